vu_ppi_shadow: RTL and testbench

- Passive snooper of Vector-06c 8255 PPI writes seen on the expansion bus.
- Keeps shadow copies of the CW, PA, PB and PC registers for NUM_PPI PPIs, with full 8255 mode-set and BSR semantics.
- Contains a parametrised PC-bit blink watcher. The watcher is armed by an external event and releases after a set number of falling edges or a timeout.
- Replaces the single-bit ruslat spy and the fixed fakerom blink counter. Fed by bus_sampler outputs.

---
 rtl/vu_ppi_shadow.sv | 151 +++++++++++++++
 tb/tb_vu_ppi_shadow.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vu_ppi_shadow.sv
// Shadow copies of Vector-06c 8255 PPI registers snooped from bus writes,
// plus a PC-bit blink watcher armed by an external event.
module vu_ppi_shadow #(
   parameter int         NUM_PPI     = 2,
   parameter logic [7:0] BASE        = 8'h00,
   parameter int         WATCH_PPI   = 0,
   parameter int         WATCH_BIT   = 3,
   parameter int         BLINK_COUNT = 4,
   parameter int         TIMEOUT     = 0
) (
   input  logic                 clk_cpu,
   input  logic                 sys_reset,
   input  logic [7:0]           shavv,
   input  logic [7:0]           data_i,
   input  logic                 wr_stb,
   input  logic                 arm_i,
   input  logic                 disarm_i,
   output logic [8*NUM_PPI-1:0] cw_o,
   output logic [8*NUM_PPI-1:0] pa_o,
   output logic [8*NUM_PPI-1:0] pb_o,
   output logic [8*NUM_PPI-1:0] pc_o,
   output logic                 watch_en_o,
   output logic                 watch_done_o,
   output logic                 watch_to_o,
   output logic [7:0]           watch_cnt_o
);

   typedef enum logic {
      IDLE,
      ARMED
   } state_t;

   logic [7:0] cw [NUM_PPI];
   logic [7:0] pa [NUM_PPI];
   logic [7:0] pb [NUM_PPI];
   logic [7:0] pc [NUM_PPI];

   state_t      state;
   logic [7:0]  cnt;
   logic [31:0] timer;
   logic        arm_r;
   logic        w_d;
   logic        done_r;
   logic        to_r;

   logic w;
   logic fall;
   logic arm_edge;
   logic last_fall;
   logic time_up;

   always_ff @(posedge clk_cpu or posedge sys_reset) begin
      if (sys_reset) begin
         for (int i = 0; i < NUM_PPI; i++) begin
            cw[i] <= '0;
            pa[i] <= '0;
            pb[i] <= '0;
            pc[i] <= '0;
         end
      end else if (wr_stb) begin
         for (int i = 0; i < NUM_PPI; i++) begin
            if (shavv[7:2] == BASE[7:2] + 6'(i)) begin
               unique case (shavv[1:0])
                  2'd3: pa[i] <= data_i;
                  2'd2: pb[i] <= data_i;
                  2'd1: pc[i] <= data_i;
                  2'd0: begin
                     // mode set clears the port latches like a real 8255
                     if (data_i[7]) begin
                        cw[i] <= data_i;
                        pa[i] <= '0;
                        pb[i] <= '0;
                        pc[i] <= '0;
                     end else begin
                        pc[i][data_i[3:1]] <= data_i[0];
                     end
                  end
               endcase
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_PPI; g++) begin : g_out
      assign cw_o[8*g +: 8] = cw[g];
      assign pa_o[8*g +: 8] = pa[g];
      assign pb_o[8*g +: 8] = pb[g];
      assign pc_o[8*g +: 8] = pc[g];
   end

   assign w         = pc[WATCH_PPI][WATCH_BIT];
   assign fall      = w_d & ~w;
   assign arm_edge  = arm_i & ~arm_r;
   assign last_fall = fall && (cnt == 8'(BLINK_COUNT - 1));
   assign time_up   = (TIMEOUT != 0) &&
                      (timer == 32'(TIMEOUT - 1));

   always_ff @(posedge clk_cpu or posedge sys_reset) begin
      if (sys_reset) begin
         state  <= IDLE;
         cnt    <= '0;
         timer  <= '0;
         arm_r  <= 1'b0;
         w_d    <= 1'b0;
         done_r <= 1'b0;
         to_r   <= 1'b0;
      end else begin
         arm_r  <= arm_i;
         w_d    <= w;
         done_r <= 1'b0;
         to_r   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (arm_edge) begin
                  state <= ARMED;
                  cnt   <= '0;
                  timer <= '0;
               end
            end
            ARMED: begin
               if (disarm_i) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (arm_edge) begin
                  cnt   <= '0;
                  timer <= '0;
               end else if (last_fall) begin
                  state  <= IDLE;
                  cnt    <= '0;
                  done_r <= 1'b1;
               end else if (fall) begin
                  cnt   <= cnt + 8'd1;
                  timer <= timer + 32'd1;
               end else if (time_up) begin
                  state <= IDLE;
                  cnt   <= '0;
                  to_r  <= 1'b1;
               end else begin
                  timer <= timer + 32'd1;
               end
            end
         endcase
      end
   end

   assign watch_en_o   = (state == ARMED);
   assign watch_done_o = done_r;
   assign watch_to_o   = to_r;
   assign watch_cnt_o  = cnt;

endmodule

// File: tb/tb_vu_ppi_shadow.sv
// Scoreboard bench for vu_ppi_shadow: a driver pushes expected snapshots
// from a behavioural model, a monitor pops and compares each cycle.
module tb_vu_ppi_shadow;

   localparam int NUM = 2;
   localparam int WP  = 0;
   localparam int WB  = 3;
   localparam int BLK = 4;
   localparam int TO  = 100;

   logic           clk_cpu = 1'b0;
   logic           sys_reset = 1'b1;
   logic [7:0]     shavv = '0;
   logic [7:0]     data_i = '0;
   logic           wr_stb = 1'b0;
   logic           arm_i = 1'b0;
   logic           disarm_i = 1'b0;
   logic [8*NUM-1:0] cw_o, pa_o, pb_o, pc_o;
   logic           watch_en_o, watch_done_o, watch_to_o;
   logic [7:0]     watch_cnt_o;

   vu_ppi_shadow #(
      .NUM_PPI(NUM), .BASE(8'h00), .WATCH_PPI(WP),
      .WATCH_BIT(WB), .BLINK_COUNT(BLK), .TIMEOUT(TO)
   ) dut (
      .clk_cpu(clk_cpu), .sys_reset(sys_reset),
      .shavv(shavv), .data_i(data_i), .wr_stb(wr_stb),
      .arm_i(arm_i), .disarm_i(disarm_i),
      .cw_o(cw_o), .pa_o(pa_o), .pb_o(pb_o), .pc_o(pc_o),
      .watch_en_o(watch_en_o), .watch_done_o(watch_done_o),
      .watch_to_o(watch_to_o), .watch_cnt_o(watch_cnt_o)
   );

   always #5 clk_cpu = ~clk_cpu;

   typedef struct {
      logic [8*NUM-1:0] cw, pa, pb, pc;
      logic en, done, to;
      logic [7:0] cnt;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   logic [7:0] m_cw [NUM];
   logic [7:0] m_pa [NUM];
   logic [7:0] m_pb [NUM];
   logic [7:0] m_pc [NUM];
   bit   m_armed, m_armp, m_wd, m_done, m_to;
   int   m_cnt, m_tmr;
   logic arm_lvl = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h @%0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic model(input bit rst, input logic [7:0] a,
                        input logic [7:0] d, input bit wr,
                        input bit arm, input bit dis);
      bit w, fall, aedge;
      exp_t e;
      if (rst) begin
         for (int i = 0; i < NUM; i++) begin
            m_cw[i] = 0; m_pa[i] = 0; m_pb[i] = 0; m_pc[i] = 0;
         end
         m_armed = 0; m_armp = 0; m_wd = 0;
         m_done = 0; m_to = 0; m_cnt = 0; m_tmr = 0;
      end else begin
         w = m_pc[WP][WB];
         fall = m_wd && !w;
         aedge = arm && !m_armp;
         m_wd = w;
         m_armp = arm;
         m_done = 0;
         m_to = 0;
         if (!m_armed) begin
            if (aedge) begin
               m_armed = 1; m_cnt = 0; m_tmr = 0;
            end
         end else if (dis) begin
            m_armed = 0; m_cnt = 0;
         end else if (aedge) begin
            m_cnt = 0; m_tmr = 0;
         end else if (fall && m_cnt == BLK - 1) begin
            m_armed = 0; m_cnt = 0; m_done = 1;
         end else if (fall) begin
            m_cnt++; m_tmr++;
         end else if (m_tmr == TO - 1) begin
            m_armed = 0; m_cnt = 0; m_to = 1;
         end else begin
            m_tmr++;
         end
         if (wr && a < 8'(4 * NUM)) begin
            int i;
            i = int'(a) / 4;
            case (int'(a) % 4)
               3: m_pa[i] = d;
               2: m_pb[i] = d;
               1: m_pc[i] = d;
               default:
                  if (d[7]) begin
                     m_cw[i] = d;
                     m_pa[i] = 0; m_pb[i] = 0; m_pc[i] = 0;
                  end else begin
                     m_pc[i][d[3:1]] = d[0];
                  end
            endcase
         end
      end
      for (int i = 0; i < NUM; i++) begin
         e.cw[8*i +: 8] = m_cw[i];
         e.pa[8*i +: 8] = m_pa[i];
         e.pb[8*i +: 8] = m_pb[i];
         e.pc[8*i +: 8] = m_pc[i];
      end
      e.en = m_armed;
      e.done = m_done;
      e.to = m_to;
      e.cnt = 8'(m_cnt);
      q.push_back(e);
   endtask

   task automatic step(input bit rst, input logic [7:0] a,
                       input logic [7:0] d, input bit wr,
                       input bit dis);
      @(posedge clk_cpu);
      #2;
      sys_reset = rst;
      shavv = a;
      data_i = d;
      wr_stb = wr;
      arm_i = arm_lvl;
      disarm_i = dis;
      model(rst, a, d, wr, arm_lvl, dis);
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      step(0, a, d, 1, 0);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 8'h00, 8'h00, 0, 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_cw"}, 32'(cw_o), 0);
      chk({tag, "_pa"}, 32'(pa_o), 0);
      chk({tag, "_pb"}, 32'(pb_o), 0);
      chk({tag, "_pc"}, 32'(pc_o), 0);
      chk({tag, "_en"}, 32'(watch_en_o), 0);
      chk({tag, "_cnt"}, 32'(watch_cnt_o), 0);
   endtask

   task automatic blink;
      wr(8'h00, 8'h07);
      idle(1);
      wr(8'h00, 8'h06);
      idle(2);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk_cpu);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("cw", 32'(cw_o), 32'(e.cw));
            chk("pa", 32'(pa_o), 32'(e.pa));
            chk("pb", 32'(pb_o), 32'(e.pb));
            chk("pc", 32'(pc_o), 32'(e.pc));
            chk("en", 32'(watch_en_o), 32'(e.en));
            chk("done", 32'(watch_done_o), 32'(e.done));
            chk("to", 32'(watch_to_o), 32'(e.to));
            chk("cnt", 32'(watch_cnt_o), 32'(e.cnt));
         end
      end
   end

   initial begin : driver
      step(1, 0, 0, 0, 0);
      #1 chk_zero("reset");
      step(1, 0, 0, 0, 0);
      idle(1);
      wr(8'h03, 8'h55); idle(1);
      wr(8'h02, 8'hAA); wr(8'h01, 8'h0F); idle(1);
      wr(8'h07, 8'h11); wr(8'h06, 8'h22); wr(8'h05, 8'h33);
      wr(8'h00, 8'h8A); idle(1);
      wr(8'h00, 8'h07); wr(8'h00, 8'h06); wr(8'h00, 8'h0F);
      wr(8'h04, 8'h90); idle(1);
      wr(8'h09, 8'hEE); step(0, 8'h03, 8'h77, 0, 0); idle(1);
      // four falls release, the fifth lands while idle
      arm_lvl = 1; idle(2);
      repeat (5) blink();
      arm_lvl = 0; idle(2);
      arm_lvl = 1; idle(105);
      arm_lvl = 0; idle(1);
      arm_lvl = 1; idle(47);
      arm_lvl = 0; idle(1);
      arm_lvl = 1; idle(105);
      arm_lvl = 0; idle(1);
      arm_lvl = 1; idle(1);
      blink(); blink();
      wr(8'h00, 8'h07); idle(1);
      wr(8'h00, 8'h06);
      step(0, 8'h00, 8'h00, 0, 1);
      idle(3);
      arm_lvl = 0; idle(1);
      arm_lvl = 1; idle(1);
      blink();
      wr(8'h00, 8'h07); idle(1);
      step(1, 0, 0, 0, 0);
      #1 chk_zero("async_rst");
      arm_lvl = 0;
      idle(3);
      for (int n = 0; n < 1500; n++) begin
         logic [7:0] a, d;
         bit w, dis;
         a = 8'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) begin
            d = 8'($urandom);
         end else begin
            a = 8'h00;
            d = {4'h0, 3'd3, 1'($urandom_range(0, 1))};
         end
         w = ($urandom_range(0, 9) < 7);
         dis = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 29) == 0) arm_lvl = ~arm_lvl;
         step(0, a, d, w, dis);
      end
      idle(2);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
